// File: rtl/bot4x_if.sv
// bot4x_if: Picoblaze I/O register interface serving NUM_BOTS Rojobot banks with atomic snapshot loads.
// Optional snapshot sequence counters and the SnapSeq port are enabled by BOT4X_SNAPSHOT_SEQ_EN.
module bot4x_if #(
    parameter int NUM_BOTS = 2,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Wr_Strobe,
    input  logic                       Rd_Strobe,
    input  logic [7:0]                 AddrIn,
    input  logic [DATA_W-1:0]          DataIn,
    output logic [DATA_W-1:0]          DataOut,
    input  logic [NUM_BOTS*DATA_W-1:0] MotCtl,
    input  logic [NUM_BOTS*DATA_W-1:0] BotConfig,
    output logic [NUM_BOTS*DATA_W-1:0] LocX,
    output logic [NUM_BOTS*DATA_W-1:0] LocY,
    output logic [NUM_BOTS*DATA_W-1:0] BotInfo,
    output logic [NUM_BOTS*DATA_W-1:0] Sensors,
    output logic [NUM_BOTS*DATA_W-1:0] MapX,
    output logic [NUM_BOTS*DATA_W-1:0] MapY,
    input  logic [NUM_BOTS*2-1:0]      MapVal,
`ifdef BOT4X_SNAPSHOT_SEQ_EN
    output logic [NUM_BOTS*DATA_W-1:0] SnapSeq,
`endif
    output logic [NUM_BOTS-1:0]        upd_sysregs,
    input  logic [NUM_BOTS-1:0]        upd_ack
);

    localparam logic [DATA_W-1:0] C_55 = DATA_W'(8'h55);
    localparam logic [DATA_W-1:0] C_66 = DATA_W'(8'h66);
    localparam logic [DATA_W-1:0] C_BB = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] C_MAX = {DATA_W{1'b1}};

    logic [DATA_W-1:0] r_hx [NUM_BOTS];
    logic [DATA_W-1:0] r_hy [NUM_BOTS];
    logic [DATA_W-1:0] r_hi [NUM_BOTS];
    logic [DATA_W-1:0] r_hs [NUM_BOTS];
    logic [DATA_W-1:0] r_locx [NUM_BOTS];
    logic [DATA_W-1:0] r_locy [NUM_BOTS];
    logic [DATA_W-1:0] r_info [NUM_BOTS];
    logic [DATA_W-1:0] r_sens [NUM_BOTS];
    logic [DATA_W-1:0] r_mapx [NUM_BOTS];
    logic [DATA_W-1:0] r_mapy [NUM_BOTS];
    logic [DATA_W-1:0] r_ovr  [NUM_BOTS];
`ifdef BOT4X_SNAPSHOT_SEQ_EN
    logic [DATA_W-1:0] r_seq  [NUM_BOTS];
`endif
    logic [NUM_BOTS-1:0] r_ld_pend;
    logic [NUM_BOTS-1:0] r_upd;
    logic [DATA_W-1:0]   r_dout;

    logic [1:0]          w_bank;
    logic [3:0]          w_off;
    logic [NUM_BOTS-1:0] w_sel;
    logic [NUM_BOTS-1:0] w_wr;
    logic [NUM_BOTS-1:0] w_set;
    logic [NUM_BOTS-1:0] w_clr_ovr;
    logic [DATA_W-1:0]   w_rd;
    logic                w_unused;

    assign w_bank   = AddrIn[5:4];
    assign w_off    = AddrIn[3:0];
    assign w_unused = ^{Rd_Strobe, AddrIn[7:6]};

    // Out-of-range banks never match any w_sel bit, so they are inert for writes and read as 0.
    always_comb begin
        w_sel     = '0;
        w_wr      = '0;
        w_set     = '0;
        w_clr_ovr = '0;
        for (int i = 0; i < NUM_BOTS; i++) begin
            w_sel[i]     = (w_bank == 2'(i));
            w_wr[i]      = Wr_Strobe && w_sel[i];
            w_set[i]     = w_wr[i] && (w_off == 4'hE);
            w_clr_ovr[i] = w_wr[i] && (w_off == 4'hF);
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_BOTS; i++) begin
            if (w_sel[i]) begin
                case (w_off)
                    4'h0: w_rd = MotCtl[i*DATA_W +: DATA_W];
                    4'h1: w_rd = r_hx[i];
                    4'h2: w_rd = r_hy[i];
                    4'h3: w_rd = r_hi[i];
                    4'h4: w_rd = r_hs[i];
`ifdef BOT4X_SNAPSHOT_SEQ_EN
                    4'h5: w_rd = r_seq[i];
`else
                    4'h5: w_rd = C_55;
`endif
                    4'h6: w_rd = C_66;
                    4'h7: w_rd = BotConfig[i*DATA_W +: DATA_W];
                    4'h8: w_rd = r_mapx[i];
                    4'h9: w_rd = r_mapy[i];
                    4'hA: w_rd = DATA_W'(MapVal[i*2 +: 2]);
                    4'hB: w_rd = C_BB;
                    4'hE: w_rd = DATA_W'(r_upd[i]);
                    4'hF: w_rd = r_ovr[i];
                    default: w_rd = '0;
                endcase
            end
        end
    end

    // Update handshake: a set write raises upd_sysregs[b] and it holds until the application
    // pulses upd_ack[b]; a set arriving while still raised and unacknowledged counts as an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout    <= '0;
            r_ld_pend <= '0;
            r_upd     <= '0;
            for (int i = 0; i < NUM_BOTS; i++) begin
                r_hx[i]   <= '0;
                r_hy[i]   <= '0;
                r_hi[i]   <= '0;
                r_hs[i]   <= '0;
                r_locx[i] <= '0;
                r_locy[i] <= '0;
                r_info[i] <= '0;
                r_sens[i] <= '0;
                r_mapx[i] <= '0;
                r_mapy[i] <= '0;
                r_ovr[i]  <= '0;
`ifdef BOT4X_SNAPSHOT_SEQ_EN
                r_seq[i]  <= '0;
`endif
            end
        end else begin
            r_dout <= w_rd;
            for (int i = 0; i < NUM_BOTS; i++) begin
                if (w_wr[i]) begin
                    case (w_off)
                        4'h1: r_hx[i]   <= DataIn;
                        4'h2: r_hy[i]   <= DataIn;
                        4'h3: r_hi[i]   <= DataIn;
                        4'h4: r_hs[i]   <= DataIn;
                        4'h8: r_mapx[i] <= DataIn;
                        4'h9: r_mapy[i] <= DataIn;
                        default: ;
                    endcase
                end
                // Snapshot copies pre-edge holding values, so all four change together.
                if (r_ld_pend[i]) begin
                    r_locx[i] <= r_hx[i];
                    r_locy[i] <= r_hy[i];
                    r_info[i] <= r_hi[i];
                    r_sens[i] <= r_hs[i];
`ifdef BOT4X_SNAPSHOT_SEQ_EN
                    r_seq[i]  <= r_seq[i] + DATA_W'(1);
`endif
                end
                r_ld_pend[i] <= w_wr[i] && (w_off == 4'hC);
                if (w_set[i]) begin
                    r_upd[i] <= 1'b1;
                end else if (upd_ack[i]) begin
                    r_upd[i] <= 1'b0;
                end
                if (w_clr_ovr[i]) begin
                    r_ovr[i] <= '0;
                end else if (w_set[i] && r_upd[i] && !upd_ack[i] && (r_ovr[i] != C_MAX)) begin
                    r_ovr[i] <= r_ovr[i] + DATA_W'(1);
                end
            end
        end
    end

    assign DataOut     = r_dout;
    assign upd_sysregs = r_upd;

    for (genvar g = 0; g < NUM_BOTS; g++) begin : g_out
        assign LocX[g*DATA_W +: DATA_W]    = r_locx[g];
        assign LocY[g*DATA_W +: DATA_W]    = r_locy[g];
        assign BotInfo[g*DATA_W +: DATA_W] = r_info[g];
        assign Sensors[g*DATA_W +: DATA_W] = r_sens[g];
        assign MapX[g*DATA_W +: DATA_W]    = r_mapx[g];
        assign MapY[g*DATA_W +: DATA_W]    = r_mapy[g];
`ifdef BOT4X_SNAPSHOT_SEQ_EN
        assign SnapSeq[g*DATA_W +: DATA_W] = r_seq[g];
`endif
    end

endmodule

// File: tb/tb_bot4x_if.sv
// Self-checking bench for bot4x_if (NUM_BOTS=2, DATA_W=8) using an expected-value queue and a monitor.
module tb_bot4x_if;

  localparam int NB = 2;
  localparam int DW = 8;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             Wr_Strobe = 1'b0;
  logic             Rd_Strobe = 1'b0;
  logic [7:0]       AddrIn = '0;
  logic [DW-1:0]    DataIn = '0;
  logic [DW-1:0]    DataOut;
  logic [NB*DW-1:0] MotCtl = 16'hB1A0;
  logic [NB*DW-1:0] BotConfig = 16'hC3C2;
  logic [NB*DW-1:0] LocX, LocY, BotInfo, Sensors, MapX, MapY;
  logic [NB*2-1:0]  MapVal = 4'b1110;
  logic [NB-1:0]    upd_sysregs;
  logic [NB-1:0]    upd_ack = '0;
`ifdef BOT4X_SNAPSHOT_SEQ_EN
  logic [NB*DW-1:0] SnapSeq;
`endif

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bot4x_if #(.NUM_BOTS(NB), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .Wr_Strobe(Wr_Strobe), .Rd_Strobe(Rd_Strobe),
    .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut),
    .MotCtl(MotCtl), .BotConfig(BotConfig),
    .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
    .MapX(MapX), .MapY(MapY), .MapVal(MapVal),
`ifdef BOT4X_SNAPSHOT_SEQ_EN
    .SnapSeq(SnapSeq),
`endif
    .upd_sysregs(upd_sysregs), .upd_ack(upd_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: all start and end just after a falling edge
  task automatic push_chk(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    exp_q.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    chk_req   = 1'b0;
    Wr_Strobe = 1'b0;
    upd_ack   = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [DW-1:0] d);
    AddrIn = a; DataIn = d; Wr_Strobe = 1'b1;
    step();
  endtask

  task automatic wr_chk(input logic [7:0] a, input int sel, input logic [31:0] exp, input string name);
    AddrIn = a; DataIn = '0; Wr_Strobe = 1'b1;
    push_chk(sel, exp, name);
    step();
  endtask

  task automatic wr_ack(input logic [7:0] a, input logic [NB-1:0] ack);
    AddrIn = a; DataIn = '0; Wr_Strobe = 1'b1; upd_ack = ack;
    step();
  endtask

  task automatic ack(input logic [NB-1:0] bits);
    upd_ack = bits;
    step();
  endtask

  task automatic rd(input logic [7:0] a, input logic [DW-1:0] exp, input string name);
    AddrIn = a;
    push_chk(0, 32'(exp), name);
    step();
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    push_chk(sel, exp, name);
    step();
  endtask

  // scoreboard monitor: sel 0 DataOut, 1 bank1 snapshot, 2 bank0 snapshot, 3 upd_sysregs, 4 MapX/MapY, 5 SnapSeq[0]
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      if (chk_req) begin
        #1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: check requested with empty queue");
        end else begin
          e = exp_q.pop_front();
          case (e.sel)
            0: act = 32'(DataOut);
            1: act = {LocX[15:8], LocY[15:8], BotInfo[15:8], Sensors[15:8]};
            2: act = {LocX[7:0], LocY[7:0], BotInfo[7:0], Sensors[7:0]};
            3: act = 32'(upd_sysregs);
            4: act = {MapX, MapY};
`ifdef BOT4X_SNAPSHOT_SEQ_EN
            5: act = 32'(SnapSeq[7:0]);
`endif
            default: act = 32'hDEAD_BEEF;
          endcase
          if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] rst_exp [16];
    rst_exp = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h66, 8'hC2,
                8'h00, 8'h00, 8'h02, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BOT4X_SNAPSHOT_SEQ_EN
    rst_exp[5] = 8'h00;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();

    // reset state
    chk(1, 32'h0, "rst_snap_b1");
    chk(2, 32'h0, "rst_snap_b0");
    chk(3, 32'h0, "rst_upd");
    chk(4, 32'h0, "rst_map");
    for (int i = 0; i < 16; i++) rd(8'(i), rst_exp[i], $sformatf("rst_rd_off%0h", i));
    rd(8'h1A, 8'h03, "mapval_b1");
    rd(8'h17, 8'hC3, "botcfg_b1");

    // atomic load on bank 1
    wr(8'h11, 8'h11); wr(8'h12, 8'h22); wr(8'h13, 8'h33); wr(8'h14, 8'h44);
    chk(1, 32'h0, "hold_not_visible");
    rd(8'h13, 8'h33, "hold_readback");
    wr_chk(8'h1C, 1, 32'h0, "load_not_yet");
    chk(1, 32'h11223344, "load_atomic");
    chk(2, 32'h0, "load_other_bank");
    rd(8'h1C, 8'h00, "off_c_reads0");

    // map address registers
    wr(8'h08, 8'h12); wr(8'h09, 8'h34); wr(8'h18, 8'h56); wr(8'h19, 8'h78);
    chk(4, 32'h56127834, "map_regs");
    rd(8'h18, 8'h56, "mapx_readback");
    wr(8'h00, 8'hFF);
    rd(8'h00, 8'hA0, "ro_write_ignored");

    // update handshake
    wr(8'h0E, 8'h00);
    chk(3, 32'h1, "upd_set");
    ack(2'b01);
    chk(3, 32'h0, "upd_ack_clear");
    wr(8'h0E, 8'h00); wr(8'h0E, 8'h00);
    rd(8'h0F, 8'h01, "overrun_one");
    rd(8'h0E, 8'h01, "upd_readback");
    wr_ack(8'h0E, 2'b01);
    chk(3, 32'h1, "set_ack_same");
    rd(8'h0F, 8'h01, "set_ack_no_ovr");
    wr(8'h0F, 8'h5A);
    rd(8'h0F, 8'h00, "overrun_clear");

    // saturation
    for (int i = 0; i < 260; i++) wr(8'h0E, 8'h00);
    rd(8'h0F, 8'hFF, "overrun_sat");
    rd(8'h1F, 8'h00, "overrun_other_bank");

    // out-of-range bank and ignored address bits
    wr(8'h31, 8'hAA);
    rd(8'h31, 8'h00, "oob_read");
    rd(8'h11, 8'h11, "oob_no_write_b1");
    rd(8'h01, 8'h00, "oob_no_write_b0");
    rd(8'hD1, 8'h11, "addr_hi_ignored");

`ifdef BOT4X_SNAPSHOT_SEQ_EN
    wr(8'h0C, 8'h00); wr(8'h0C, 8'h00); wr(8'h0C, 8'h00);
    chk(5, 32'h3, "snapseq_port_3");
    rd(8'h05, 8'h03, "snapseq_rd_3");
    for (int i = 0; i < 253; i++) wr(8'h0C, 8'h00);
    chk(5, 32'h0, "snapseq_port_wrap");
    rd(8'h05, 8'h00, "snapseq_rd_wrap");
`endif

    // reset mid-operation discards flag and pending load
    wr(8'h11, 8'h99);
    wr(8'h1E, 8'h00);
    wr(8'h1C, 8'h00);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk(3, 32'h0, "midrst_upd");
    chk(1, 32'h0, "midrst_snap");
    rd(8'h11, 8'h00, "midrst_hold");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bot4x_if.md
Name: bot4x_if

Overview:
- Parametrised successor to the BOT 3.x Picoblaze register interface. It serves NUM_BOTS Rojobot emulators from one Picoblaze I/O port space.
- Per bot, it holds internal copies of LocX, LocY, BotInfo and Sensors. A single load command copies all four to the system-visible registers in the same cycle, so system logic always sees a consistent snapshot.
- The upd_sysregs toggle is replaced by a sticky per-bot update flag with acknowledge handshake and overrun counting.
- Sits between the Picoblaze, the world-map logic and the application.

Parameters:
- NUM_BOTS, 2, number of bot banks (1..4).
- DATA_W, 8, register width (fixed to Picoblaze byte width; ≥8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Wr_Strobe  in  1  Picoblaze write strobe.
- Rd_Strobe  in  1  Picoblaze read strobe (unused; reads are free-running).
- AddrIn  in  8  port address: [5:4] bank b, [3:0] offset.
- DataIn  in  DATA_W  write data.
- DataOut  out  DATA_W  registered read data.
- MotCtl  in  NUM_BOTS*DATA_W  per-bot motor control (bank b at [b*DATA_W +: DATA_W]; same packing for all vectors below).
- BotConfig  in  NUM_BOTS*DATA_W  per-bot configuration.
- LocX, LocY, BotInfo, Sensors  out  NUM_BOTS*DATA_W each  system-visible snapshot registers.
- MapX, MapY  out  NUM_BOTS*DATA_W each  world-map column/row address.
- MapVal  in  NUM_BOTS*2  map value per bot.
- upd_sysregs  out  NUM_BOTS  sticky update flag per bot.
- upd_ack  in  NUM_BOTS  one-cycle acknowledge from application.

Behaviour:
- Reset (reset=0, asynchronous): every output register, holding register, pending-load bit and overrun counter is cleared to 0.
- Bank decode:
  - b = AddrIn[5:4].
  - If b ≥ NUM_BOTS: writes are ignored; reads return 0.
  - AddrIn[7:6] is ignored.
- Offset map (R = read, W = write):
  - 0 R: MotCtl[b].
  - 1..4 R/W: holding LocX, LocY, BotInfo, Sensors.
  - 5 R: 0x55 (see Optional Feature).
  - 6 R: 0x66.
  - 7 R: BotConfig[b].
  - 8, 9 R/W: MapX, MapY. A write updates the output register on the strobe edge.
  - A R: MapVal[b], zero-extended.
  - B R: 0xBB.
  - C W: load snapshot. R returns 0.
  - D: reserved. R returns 0.
  - E W: set update flag. R returns upd_sysregs[b] in bit 0.
  - F R: overrun count. W (any data) clears the count.
  - Writes to read-only offsets have no effect.
- Read path: DataOut is registered, one-cycle latency. AddrIn sampled at edge k gives data valid after edge k. Updates every cycle regardless of strobes.
- Load:
  - Write to offset C at edge k sets ld_pend[b].
  - At edge k+1, LocX/LocY/BotInfo/Sensors[b] take the holding values and ld_pend[b] clears.
  - A holding-register write at edge k is therefore captured by the load at k+1.
  - Other banks are unaffected.
- Update flag:
  - Write offset E of bank b: upd_sysregs[b] ← 1 on that edge.
  - upd_ack[b]=1 (no simultaneous set): clears the flag next edge.
  - Set while flag already 1 and no ack: overrun[b] increments, saturating at 2^DATA_W−1.
  - Set and ack in the same cycle: flag stays 1, no overrun.
  - Clear-overrun write and increment in the same cycle: clear wins, count = 0.
- Reset mid-operation discards pending loads and flags immediately.

Optional Feature:
- Macro BOT4X_SNAPSHOT_SEQ_EN.
- Defined:
  - Each bank has a DATA_W-bit snapshot sequence counter, incremented (wrapping) at the same edge the snapshot loads.
  - Offset 5 reads the counter.
  - Adds output port SnapSeq (NUM_BOTS*DATA_W) mirroring the counters.
  - Reset value 0.
- Undefined: no counter and no SnapSeq port; offset 5 reads 0x55.

Test Plan:
- Reset: after reset=0 then 1, read every offset of bank 0 → MotCtl/BotConfig/MapVal values as driven, 0 for the holding registers (offsets 1–4), 0x55/0x66/0xBB constants, 0 elsewhere; all outputs 0.
- Atomic load: write bank1 offsets 1–4 = 0x11,0x22,0x33,0x44 → LocX..Sensors[1] still 0. Write offset 0x1C → all four update at the same edge, one cycle later; bank 0 unchanged.
- Update handshake: write 0x0E → upd_sysregs[0]=1. Pulse upd_ack[0] → 0. Write E twice without ack → offset F reads 1. Write E with upd_ack[0] in the same cycle → flag 1, count stays 1. Write F → reads 0.
- Saturation: 260 E-writes without ack → offset F reads 0xFF.
- Out-of-range bank (NUM_BOTS=2): write 0x31 = 0xAA → no register changes; read 0x31 → 0x00.
- With BOT4X_SNAPSHOT_SEQ_EN: three loads of bank 0 → offset 5 and SnapSeq[0] = 3; after 256 loads the counter wraps to 0.
